// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage.
//   op_class_t : coarse instruction class carried into execute
//   cause_t    : trap cause codes (mcause encoding)
//   OPC_*      : 7-bit RV32I major opcodes, including the 2'b11 length bits
package decode_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP     = 4'd1,
    OP_IMM = 4'd2,
    LOAD   = 4'd3,
    STORE  = 4'd4,
    BRANCH = 4'd5,
    JAL    = 4'd6,
    JALR   = 4'd7,
    LUI    = 4'd8,
    AUIPC  = 4'd9,
    SYSTEM = 4'd10,
    FENCE  = 4'd11
  } op_class_t;

  typedef enum logic [3:0] {
    CAUSE_INS_MISALIGN = 4'd0,
    CAUSE_ILLEGAL      = 4'd2,
    CAUSE_EBREAK       = 4'd3,
    CAUSE_ECALL        = 4'd11
  } cause_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INS_ECALL  = 32'h00000073;
  localparam logic [31:0] INS_EBREAK = 32'h00100073;

  // Unknown opcodes (including any word whose low two bits are not 2'b11)
  // map to OP_NOP, which the decoder treats as illegal.
  function automatic op_class_t class_of(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI:    return LUI;
      OPC_AUIPC:  return AUIPC;
      OPC_JAL:    return JAL;
      OPC_JALR:   return JALR;
      OPC_BRANCH: return BRANCH;
      OPC_LOAD:   return LOAD;
      OPC_STORE:  return STORE;
      OPC_OP_IMM: return OP_IMM;
      OPC_OP:     return OP;
      OPC_FENCE:  return FENCE;
      OPC_SYSTEM: return SYSTEM;
      default:    return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32 x XLEN integer register file, two combinational read ports, one write
// port. A write presented in the same cycle as a read of the same register
// is forwarded to the read port; the array itself updates at the posedge.
// x0 always reads zero and writes to it are dropped. Not reset.
// Ports:
//   clk                    clock
//   rs1_index / rs1_data   read port 1
//   rs2_index / rs2_data   read port 2
//   rd_we, rd_index, rd_data  write port
module decode_stage_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic [4:0]      rs1_index,
  input  logic [4:0]      rs2_index,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            rd_we,
  input  logic [4:0]      rd_index,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] regs [32];
  logic            wr_live;

  assign wr_live = rd_we && (rd_index != 5'd0);

  always_ff @(posedge clk) begin
    if (wr_live) regs[rd_index] <= rd_data;
  end

  always_comb begin
    rs1_data = regs[rs1_index];
    if (rs1_index == 5'd0)                      rs1_data = '0;
    else if (wr_live && rd_index == rs1_index)  rs1_data = rd_data;
  end

  always_comb begin
    rs2_data = regs[rs2_index];
    if (rs2_index == 5'd0)                      rs2_data = '0;
    else if (wr_live && rd_index == rs2_index)  rs2_data = rd_data;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the IF/ID slot, reads operands from the
// register file (with writeback forwarding), builds the immediate, detects
// load-use hazards and registers the result into the ID/EX slot.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   pipe_flush               current IF/ID slot is dead (fetch redirect)
//   if_id__*                 slot from fetch: pc, ins, misalign, predict,
//                            fetch-inserted bubble flag
//   wb_id__*                 register file write port from writeback
//   data_hazard              combinational load-use stall request to fetch
//   id_ex__*                 registered ID/EX slot
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000040,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_flush,
  input  logic [XLEN-1:0] if_id__pc,
  input  logic [31:0]     if_id__ins,
  input  logic            if_id__ins_misalign,
  input  logic            if_id__predict_taken,
  input  logic            if_id__data_hazard,
  input  logic            wb_id__rd_we,
  input  logic [4:0]      wb_id__rd_index,
  input  logic [XLEN-1:0] wb_id__rd_data,
  output logic            data_hazard,
  output logic            id_ex__valid,
  output logic [XLEN-1:0] id_ex__pc,
  output logic [XLEN-1:0] id_ex__rs1_data,
  output logic [XLEN-1:0] id_ex__rs2_data,
  output logic [4:0]      id_ex__rs1_index,
  output logic [4:0]      id_ex__rs2_index,
  output logic [4:0]      id_ex__rd_index,
  output logic            id_ex__rd_we,
  output logic [XLEN-1:0] id_ex__imm,
  output logic [2:0]      id_ex__funct3,
  output logic            id_ex__funct7_5,
  output op_class_t       id_ex__op_class,
  output logic            id_ex__is_load,
  output logic            id_ex__is_store,
  output logic            id_ex__predict_taken,
  output logic            id_ex__trap,
  output cause_t          id_ex__trap_cause
);

  logic [31:0] ins;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;

  assign ins    = if_id__ins;
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];
  assign rd     = ins[11:7];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'h000};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  op_class_t   dec_class;
  logic        legal;
  logic        use_rs1, use_rs2;
  logic        wr_class;
  logic        dec_load, dec_store;
  logic        is_ecall, is_ebreak;
  logic [31:0] dec_imm;

  always_comb begin
    dec_class = class_of(ins[6:0]);
    legal     = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    wr_class  = 1'b0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    dec_imm   = imm_i;
    case (dec_class)
      OP: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        wr_class = 1'b1;
        dec_imm  = '0;
        // funct7=0100000 only exists for sub and sra
        legal    = (funct7 == 7'h00) ||
                   (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_IMM: begin
        use_rs1  = 1'b1;
        wr_class = 1'b1;
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      LOAD: begin
        use_rs1  = 1'b1;
        wr_class = 1'b1;
        dec_load = 1'b1;
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      STORE: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_store = 1'b1;
        dec_imm   = imm_s;
        legal     = !funct3[2] && (funct3 != 3'b011);
      end
      BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = imm_b;
        legal   = (funct3[2:1] != 2'b01);
      end
      JAL: begin
        wr_class = 1'b1;
        dec_imm  = imm_j;
      end
      JALR: begin
        use_rs1  = 1'b1;
        wr_class = 1'b1;
      end
      LUI, AUIPC: begin
        wr_class = 1'b1;
        dec_imm  = imm_u;
      end
      SYSTEM: begin
        // No CSR support: anything other than ecall/ebreak is illegal.
        is_ecall  = (ins == INS_ECALL);
        is_ebreak = (ins == INS_EBREAK);
        legal     = is_ecall || is_ebreak;
      end
      FENCE: begin
      end
      default: legal = 1'b0;
    endcase
  end

  logic   dec_trap;
  cause_t dec_cause;
  logic   dec_rd_we;

  assign dec_trap  = if_id__ins_misalign || !legal || is_ecall || is_ebreak;
  assign dec_rd_we = wr_class && (rd != 5'd0) && !dec_trap;

  always_comb begin
    dec_cause = CAUSE_INS_MISALIGN;
    if (if_id__ins_misalign) dec_cause = CAUSE_INS_MISALIGN;
    else if (!legal)         dec_cause = CAUSE_ILLEGAL;
    else if (is_ecall)       dec_cause = CAUSE_ECALL;
    else if (is_ebreak)      dec_cause = CAUSE_EBREAK;
  end

  logic [4:0]      rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rs1_idx = use_rs1 ? ins[19:15] : 5'd0;
  assign rs2_idx = use_rs2 ? ins[24:20] : 5'd0;

  decode_stage_regfile #(.XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rs1_index (rs1_idx),
    .rs2_index (rs2_idx),
    .rs1_data  (rs1_val),
    .rs2_data  (rs2_val),
    .rd_we     (wb_id__rd_we),
    .rd_index  (wb_id__rd_index),
    .rd_data   (wb_id__rd_data)
  );

  // Unused source indices are already forced to 0, so they can never match
  // a nonzero load destination. Trap slots never stall.
  logic src_match;
  logic live;

  assign src_match = ((rs1_idx != 5'd0) && (rs1_idx == id_ex__rd_index)) ||
                     ((rs2_idx != 5'd0) && (rs2_idx == id_ex__rd_index));

  assign data_hazard = id_ex__valid && id_ex__is_load && (id_ex__rd_index != 5'd0) &&
                       src_match && !dec_trap && !pipe_flush && !if_id__data_hazard;

  assign live = !pipe_flush && !if_id__data_hazard && !data_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex__valid         <= 1'b0;
      id_ex__pc            <= RESET_PC;
      id_ex__rs1_data      <= '0;
      id_ex__rs2_data      <= '0;
      id_ex__rs1_index     <= '0;
      id_ex__rs2_index     <= '0;
      id_ex__rd_index      <= '0;
      id_ex__rd_we         <= 1'b0;
      id_ex__imm           <= '0;
      id_ex__funct3        <= '0;
      id_ex__funct7_5      <= 1'b0;
      id_ex__op_class      <= OP_NOP;
      id_ex__is_load       <= 1'b0;
      id_ex__is_store      <= 1'b0;
      id_ex__predict_taken <= 1'b0;
      id_ex__trap          <= 1'b0;
      id_ex__trap_cause    <= CAUSE_INS_MISALIGN;
    end else begin
      id_ex__valid         <= live;
      id_ex__pc            <= if_id__pc;
      id_ex__rs1_data      <= rs1_val;
      id_ex__rs2_data      <= rs2_val;
      id_ex__rs1_index     <= rs1_idx;
      id_ex__rs2_index     <= rs2_idx;
      id_ex__rd_index      <= dec_rd_we ? rd : 5'd0;
      id_ex__imm           <= dec_imm;
      id_ex__funct3        <= funct3;
      id_ex__funct7_5      <= ins[30];
      id_ex__op_class      <= dec_class;
      id_ex__predict_taken <= if_id__predict_taken;
      id_ex__trap_cause    <= dec_cause;
      // Side-effect carrying fields are cleared in bubbles; trap slots
      // never write a register or touch memory.
      id_ex__rd_we         <= live && dec_rd_we;
      id_ex__is_load       <= live && dec_load && !dec_trap;
      id_ex__is_store      <= live && dec_store && !dec_trap;
      id_ex__trap          <= live && dec_trap;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pipe_flush = 1'b0;
  logic [31:0] if_id__pc = '0;
  logic [31:0] if_id__ins = '0;
  logic        if_id__ins_misalign = 1'b0;
  logic        if_id__predict_taken = 1'b0;
  logic        if_id__data_hazard = 1'b0;
  logic        wb_id__rd_we = 1'b0;
  logic [4:0]  wb_id__rd_index = '0;
  logic [31:0] wb_id__rd_data = '0;
  logic        data_hazard;
  logic        id_ex__valid;
  logic [31:0] id_ex__pc, id_ex__rs1_data, id_ex__rs2_data, id_ex__imm;
  logic [4:0]  id_ex__rs1_index, id_ex__rs2_index, id_ex__rd_index;
  logic        id_ex__rd_we, id_ex__funct7_5, id_ex__is_load, id_ex__is_store;
  logic        id_ex__predict_taken, id_ex__trap;
  logic [2:0]  id_ex__funct3;
  op_class_t   id_ex__op_class;
  cause_t      id_ex__trap_cause;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .if_id__pc(if_id__pc), .if_id__ins(if_id__ins),
    .if_id__ins_misalign(if_id__ins_misalign),
    .if_id__predict_taken(if_id__predict_taken),
    .if_id__data_hazard(if_id__data_hazard),
    .wb_id__rd_we(wb_id__rd_we), .wb_id__rd_index(wb_id__rd_index),
    .wb_id__rd_data(wb_id__rd_data),
    .data_hazard(data_hazard), .id_ex__valid(id_ex__valid), .id_ex__pc(id_ex__pc),
    .id_ex__rs1_data(id_ex__rs1_data), .id_ex__rs2_data(id_ex__rs2_data),
    .id_ex__rs1_index(id_ex__rs1_index), .id_ex__rs2_index(id_ex__rs2_index),
    .id_ex__rd_index(id_ex__rd_index), .id_ex__rd_we(id_ex__rd_we),
    .id_ex__imm(id_ex__imm), .id_ex__funct3(id_ex__funct3),
    .id_ex__funct7_5(id_ex__funct7_5), .id_ex__op_class(id_ex__op_class),
    .id_ex__is_load(id_ex__is_load), .id_ex__is_store(id_ex__is_store),
    .id_ex__predict_taken(id_ex__predict_taken), .id_ex__trap(id_ex__trap),
    .id_ex__trap_cause(id_ex__trap_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  cls;
    logic        use1, use2, wr, ld, st, trap, imm_chk;
    logic [3:0]  cause;
    logic [31:0] imm;
  } dec_t;

  typedef struct {
    logic        valid, rd_we, ld, st, pt, trap, f75, imm_chk;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1i, rs2i, rdi;
    logic [2:0]  f3;
    logic [3:0]  cls, cause;
  } exp_t;

  exp_t        m;
  logic [31:0] mregs [32];

  function automatic dec_t model_dec(input logic [31:0] i, input logic mis);
    dec_t d;
    logic legal, ec, eb, wcls;
    int   v;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    d.cls = 4'd0; d.use1 = 0; d.use2 = 0; d.ld = 0; d.st = 0; d.imm = '0; d.imm_chk = 0;
    legal = 1; ec = 0; eb = 0; wcls = 0; v = 0;
    case (i[6:0])
      7'h37, 7'h17: begin
        d.cls = (i[6:0] == 7'h37) ? 4'd8 : 4'd9; wcls = 1;
        d.imm = i & 32'hFFFFF000; d.imm_chk = 1;
      end
      7'h6F: begin
        d.cls = 4'd6; wcls = 1;
        v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + (i[20] ? 2048 : 0) + int'(i[30:21]) * 2;
        d.imm = 32'(v); d.imm_chk = 1;
      end
      7'h67, 7'h03, 7'h13: begin
        d.use1 = 1; wcls = 1;
        v = (i[31] ? -2048 : 0) + int'(i[30:20]);
        d.imm = 32'(v); d.imm_chk = 1;
        if (i[6:0] == 7'h67) d.cls = 4'd7;
        else if (i[6:0] == 7'h03) begin
          d.cls = 4'd3; d.ld = 1;
          legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        end else begin
          d.cls = 4'd2;
          if (f3 == 1) legal = (f7 == 0);
          if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
        end
      end
      7'h23: begin
        d.cls = 4'd4; d.use1 = 1; d.use2 = 1; d.st = 1;
        v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
        d.imm = 32'(v); d.imm_chk = 1;
        legal = (f3 <= 2);
      end
      7'h63: begin
        d.cls = 4'd5; d.use1 = 1; d.use2 = 1;
        v = (i[31] ? -4096 : 0) + (i[7] ? 2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        d.imm = 32'(v); d.imm_chk = 1;
        legal = !(f3 == 2 || f3 == 3);
      end
      7'h33: begin
        d.cls = 4'd1; d.use1 = 1; d.use2 = 1; wcls = 1;
        legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end
      7'h0F: d.cls = 4'd11;
      7'h73: begin
        d.cls = 4'd10;
        ec = (i == 32'h00000073);
        eb = (i == 32'h00100073);
        legal = ec || eb;
      end
      default: legal = 0;
    endcase
    d.trap = mis || !legal || ec || eb;
    d.cause = mis ? 4'd0 : !legal ? 4'd2 : ec ? 4'd11 : 4'd3;
    d.wr = wcls && (i[11:7] != 0) && !d.trap;
    d.ld = d.ld && !d.trap;
    d.st = d.st && !d.trap;
    return d;
  endfunction

  function automatic logic model_hazard();
    dec_t d;
    logic hit;
    d = model_dec(if_id__ins, if_id__ins_misalign);
    hit = (d.use1 && if_id__ins[19:15] == m.rdi) || (d.use2 && if_id__ins[24:20] == m.rdi);
    return m.valid && m.ld && (m.rdi != 0) && hit && !d.trap && !pipe_flush && !if_id__data_hazard;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (wb_id__rd_we && wb_id__rd_index == idx) return wb_id__rd_data;
    return mregs[idx];
  endfunction

  function automatic exp_t model_next();
    exp_t n;
    dec_t d;
    logic live;
    d = model_dec(if_id__ins, if_id__ins_misalign);
    live = !pipe_flush && !if_id__data_hazard && !model_hazard();
    n.valid = live;
    n.pc = if_id__pc;
    n.pt = if_id__predict_taken;
    n.rs1i = d.use1 ? if_id__ins[19:15] : 5'd0;
    n.rs2i = d.use2 ? if_id__ins[24:20] : 5'd0;
    n.rdi = d.wr ? if_id__ins[11:7] : 5'd0;
    n.rs1d = model_read(n.rs1i);
    n.rs2d = model_read(n.rs2i);
    n.rd_we = live && d.wr;
    n.ld = live && d.ld;
    n.st = live && d.st;
    n.trap = live && d.trap;
    n.cause = d.cause;
    n.imm = d.imm;
    n.imm_chk = d.imm_chk;
    n.f3 = if_id__ins[14:12];
    n.f75 = if_id__ins[30];
    n.cls = d.cls;
    return n;
  endfunction

  function automatic exp_t reset_exp();
    exp_t n;
    n.valid = 0; n.rd_we = 0; n.ld = 0; n.st = 0; n.pt = 0; n.trap = 0; n.f75 = 0;
    n.imm_chk = 0; n.pc = 32'h40; n.rs1d = 0; n.rs2d = 0; n.imm = 0;
    n.rs1i = 0; n.rs2i = 0; n.rdi = 0; n.f3 = 0; n.cls = 0; n.cause = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= reset_exp();
    else begin
      m <= model_next();
      if (wb_id__rd_we && wb_id__rd_index != 0) mregs[wb_id__rd_index] <= wb_id__rd_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("data_hazard", 32'(data_hazard), 32'(model_hazard()));
      chk("valid", 32'(id_ex__valid), 32'(m.valid));
      chk("pc", id_ex__pc, m.pc);
      chk("predict_taken", 32'(id_ex__predict_taken), 32'(m.pt));
      chk("rd_we", 32'(id_ex__rd_we), 32'(m.rd_we));
      chk("is_load", 32'(id_ex__is_load), 32'(m.ld));
      chk("is_store", 32'(id_ex__is_store), 32'(m.st));
      chk("trap", 32'(id_ex__trap), 32'(m.trap));
      if (m.valid) begin
        chk("rs1_index", 32'(id_ex__rs1_index), 32'(m.rs1i));
        chk("rs2_index", 32'(id_ex__rs2_index), 32'(m.rs2i));
        chk("rd_index", 32'(id_ex__rd_index), 32'(m.rdi));
        chk("rs1_data", id_ex__rs1_data, m.rs1d);
        chk("rs2_data", id_ex__rs2_data, m.rs2d);
        chk("funct3", 32'(id_ex__funct3), 32'(m.f3));
        chk("funct7_5", 32'(id_ex__funct7_5), 32'(m.f75));
        chk("op_class", 32'(id_ex__op_class), 32'(m.cls));
        if (m.trap) chk("trap_cause", 32'(id_ex__trap_cause), 32'(m.cause));
        if (m.imm_chk) chk("imm", id_ex__imm, m.imm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input logic [31:0] ins, input logic [31:0] pc, input logic pt);
    if_id__ins = ins;
    if_id__pc = pc;
    if_id__predict_taken = pt;
    if_id__ins_misalign = 1'b0;
    if_id__data_hazard = 1'b0;
    pipe_flush = 1'b0;
  endtask

  // Present a slot and hold it while decode requests a stall, as fetch would.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic pt);
    int n;
    n = 0;
    set_slot(ins, pc, pt);
    #1;
    while (data_hazard && n < 3) begin
      step();
      n++;
    end
    if (n > 0) chk("stall_released", 32'(data_hazard), 32'd0);
    step();
  endtask

  logic [31:0] vec [20] = '{
    32'h0021A423, 32'hFFFFF297, 32'h02009093, 32'h0000B383, 32'hFF8100E7,
    32'h402081B3, 32'h4020D1B3, 32'h022081B3, 32'h4030D093, 32'h0000A383,
    32'h007084B3, 32'h0000A383, 32'h0071A023, 32'h0000A003, 32'h00000013,
    32'h0000000F, 32'hFE209CE3, 32'h00100073, 32'h30200073, 32'h00000067
  };

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_valid", 32'(id_ex__valid), 32'd0);
    chk("reset_pc", id_ex__pc, 32'h00000040);
    chk("reset_op_class", 32'(id_ex__op_class), 32'd0);
    #9 rst_n = 1'b1;

    // Preload every register through the writeback port while fetch sends bubbles.
    if_id__data_hazard = 1'b1;
    for (int r = 1; r < 32; r++) begin
      wb_id__rd_we = 1'b1;
      wb_id__rd_index = 5'(r);
      wb_id__rd_data = 32'h1000_0000 + 32'(r) * 32'd17;
      step();
    end
    wb_id__rd_we = 1'b0;

    // Same-cycle writeback forwarding into add x6,x5,x0
    set_slot(32'h00028333, 32'h100, 1'b0);
    wb_id__rd_we = 1'b1; wb_id__rd_index = 5'd5; wb_id__rd_data = 32'hDEADBEEF;
    step();
    chk("bypass_rs1", id_ex__rs1_data, 32'hDEADBEEF);
    chk("bypass_rd_we", 32'(id_ex__rd_we), 32'd1);

    // Write to x0 must not be visible: addi x9,x0,0
    set_slot(32'h00000493, 32'h104, 1'b0);
    wb_id__rd_index = 5'd0; wb_id__rd_data = 32'h1;
    step();
    chk("x0_read", id_ex__rs1_data, 32'h0);
    wb_id__rd_we = 1'b0;

    // lw x7,0(x1) then addi x8,x7,1, with a writeback to x7 during the stall
    set_slot(32'h0000A383, 32'h108, 1'b0);
    step();
    set_slot(32'h00138413, 32'h10C, 1'b0);
    wb_id__rd_we = 1'b1; wb_id__rd_index = 5'd7; wb_id__rd_data = 32'h12345678;
    #1;
    chk("lu_hazard", 32'(data_hazard), 32'd1);
    step();
    wb_id__rd_we = 1'b0;
    chk("lu_bubble_valid", 32'(id_ex__valid), 32'd0);
    chk("lu_hazard_one_cycle", 32'(data_hazard), 32'd0);
    step();
    chk("lu_issue_valid", 32'(id_ex__valid), 32'd1);
    chk("lu_issue_rd", 32'(id_ex__rd_index), 32'd8);
    chk("lu_issue_rs1", id_ex__rs1_data, 32'h12345678);

    // lw x7 then lui x7,1: no source operands, no stall
    set_slot(32'h0000A383, 32'h110, 1'b0);
    step();
    set_slot(32'h000013B7, 32'h114, 1'b0);
    #1;
    chk("lui_no_hazard", 32'(data_hazard), 32'd0);
    step();
    chk("lui_imm", id_ex__imm, 32'h00001000);

    // Flush wins over a pending load-use stall
    set_slot(32'h0000A383, 32'h118, 1'b0);
    step();
    set_slot(32'h00138413, 32'h11C, 1'b0);
    pipe_flush = 1'b1;
    #1;
    chk("flush_no_hazard", 32'(data_hazard), 32'd0);
    step();
    chk("flush_bubble", 32'(id_ex__valid), 32'd0);
    pipe_flush = 1'b0;

    // Traps
    set_slot(32'h00000000, 32'h120, 1'b0);
    step();
    chk("illegal_trap", 32'(id_ex__trap), 32'd1);
    chk("illegal_cause", 32'(id_ex__trap_cause), 32'd2);
    chk("illegal_rd_we", 32'(id_ex__rd_we), 32'd0);
    set_slot(32'h00000000, 32'h122, 1'b0);
    if_id__ins_misalign = 1'b1;
    step();
    chk("misalign_cause", 32'(id_ex__trap_cause), 32'd0);
    set_slot(32'h00000073, 32'h124, 1'b0);
    step();
    chk("ecall_cause", 32'(id_ex__trap_cause), 32'd11);

    // Immediates
    set_slot(32'hFE000EE3, 32'h128, 1'b1);
    step();
    chk("beq_imm", id_ex__imm, 32'hFFFFFFFC);
    set_slot(32'h001000EF, 32'h12C, 1'b0);
    step();
    chk("jal_imm", id_ex__imm, 32'h00000800);
    chk("jal_rd_we", 32'(id_ex__rd_we), 32'd1);

    // Directed table, checked by the model every cycle
    for (int k = 0; k < 20; k++)
      issue(vec[k], 32'h200 + 32'(k) * 4, 1'(k % 3 == 0));

    // Asynchronous reset in the middle of a live slot
    issue(32'h00138413, 32'h300, 1'b0);
    chk("pre_reset_valid", 32'(id_ex__valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(id_ex__valid), 32'd0);
    chk("async_reset_pc", id_ex__pc, 32'h00000040);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(32'h00028333, 32'h304, 1'b0);
    issue(32'h0000A383, 32'h308, 1'b0);
    issue(32'h007084B3, 32'h30C, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage. Consumes the IF/ID slot produced by fetch: pc, instruction word, misalign flag and predict-taken.
- Owns the 32x32 integer register file. Decodes RV32I, reads operands with write-through bypass from writeback, and generates immediates.
- Detects load-use hazards and drives `data_hazard` back to fetch.
- Registers everything into the ID/EX slot.

Parameters:
- RESET_PC, 32'h00000040, value of id_ex__pc after reset.
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- pipe_flush  in  1  fetch redirect; current IF/ID slot is dead
- if_id__pc  in  32  pc of slot
- if_id__ins  in  32  instruction word
- if_id__ins_misalign  in  1  pc[1:0]!=0
- if_id__predict_taken  in  1  fetch predicted taken
- if_id__data_hazard  in  1  slot is a fetch-inserted bubble
- wb_id__rd_we  in  1  writeback enable
- wb_id__rd_index  in  5  writeback register
- wb_id__rd_data  in  32  writeback data
- data_hazard  out  1  combinational load-use stall request to fetch
- id_ex__valid  out  1  slot holds a live instruction
- id_ex__pc  out  32
- id_ex__rs1_data, id_ex__rs2_data  out  32 each
- id_ex__rs1_index, id_ex__rs2_index, id_ex__rd_index  out  5 each
- id_ex__rd_we  out  1
- id_ex__imm  out  32  sign-extended immediate
- id_ex__funct3  out  3
- id_ex__funct7_5  out  1  ins[30]
- id_ex__op_class  out  4  decode_pkg::op_class_t
- id_ex__is_load, id_ex__is_store  out  1 each
- id_ex__predict_taken  out  1
- id_ex__trap  out  1
- id_ex__trap_cause  out  4  decode_pkg::cause_t

Reset is asynchronous and active-low on rst_n. Single clock clk.

Behaviour:
- Reset (rst_n=0, async):
  - id_ex__valid=0, id_ex__pc=RESET_PC.
  - All other id_ex__* outputs are 0; op_class=OP_NOP.
  - Register file is not reset except x0, which is hardwired 0.
- Latency: one cycle from IF/ID slot to ID/EX slot. The regfile write lands at the posedge.
- Read bypass: if wb_id__rd_we && wb_id__rd_index==rsN && rsN!=0, then rsN_data=wb_id__rd_data in the same cycle. Index 0 always reads 0; writes to x0 are ignored.
- Operand usage per op_class:
  - rs1 used by: OP, OP_IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 used by: OP, STORE, BRANCH.
  - Unused indices are forced to 0 in id_ex and never cause a hazard.
- Load-use hazard: data_hazard=1 iff all of the following hold:
  - id_ex__valid && id_ex__is_load && id_ex__rd_index!=0;
  - (used rs1==id_ex__rd_index) or (used rs2==id_ex__rd_index);
  - !pipe_flush && !if_id__data_hazard.
- data_hazard is purely combinational. No pipe_flush or current-slot validity term is registered.
- On hazard, fetch holds its pc and re-presents the same slot next cycle. Decode writes a bubble into ID/EX (valid=0, rd_we=0, is_load=0, is_store=0, trap=0). The re-presented instruction then sees no hazard, since the previous ID/EX is now a bubble.
- live = !pipe_flush && !if_id__data_hazard && !data_hazard. On each posedge: id_ex__valid<=live. Payload fields update every cycle; consumers gate on valid.
- Traps, with priority misalign > illegal:
  - if_id__ins_misalign → trap=1, cause=CAUSE_INS_MISALIGN, rd_we=0.
  - Illegal instruction (ins[1:0]!=2'b11, unknown opcode, or bad funct3/funct7 for OP/OP_IMM shifts/LOAD/STORE/BRANCH) → trap=1, cause=CAUSE_ILLEGAL, rd_we=0.
  - SYSTEM ecall/ebreak → trap=1 with CAUSE_ECALL/CAUSE_EBREAK.
  - A trap slot still has valid=1 and does not request a hazard.
- Immediates:
  - I, S, B, U and J formats per RV32I, sign-extended from ins[31].
  - U is ins[31:12]<<12.
  - B and J have bit0=0.
- rd_we = 1 for OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR when rd!=0; otherwise 0.
- id_ex__predict_taken passes through if_id__predict_taken.
- Simultaneous events:
  - pipe_flush dominates hazard: data_hazard=0 and a bubble is written.
  - A writeback to the same register as an in-flight hazard compare does not suppress the hazard.

Decomposition:
- decode_pkg:
  - op_class_t: OP_NOP, OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE.
  - cause_t: CAUSE_INS_MISALIGN=0, CAUSE_ILLEGAL=2, CAUSE_EBREAK=3, CAUSE_ECALL=11.
  - Opcode constants (7-bit).
- One sub-module, regfile: 2 read ports and 1 write port, write-through bypass, x0 hardwired. decode_stage instantiates it and contains the decoder, hazard logic and ID/EX register.

Test Plan:
- Reset: rst_n=0 mid-run with id_ex__valid=1 → valid=0 and pc=32'h40 immediately, without waiting for a clock edge.
- Bypass:
  - Write x5=32'hDEADBEEF via wb in the same cycle as "add x6,x5,x0" decodes → id_ex__rs1_data=32'hDEADBEEF.
  - x0 write of 32'h1 → reads 0.
- Load-use:
  - "lw x7,0(x1)" then "addi x8,x7,1" → data_hazard=1 for exactly one cycle and a bubble enters ID/EX.
  - The re-presented addi issues next cycle with valid=1.
  - "lw x7" then "lui x7,1" → no hazard.
- Flush: pipe_flush=1 while the load-use condition holds → data_hazard=0 and id_ex__valid=0 next cycle.
- Traps:
  - ins=32'h00000000 → trap=1, cause=2, rd_we=0.
  - Misalign with an illegal word → cause=0.
  - ecall (32'h00000073) → cause=11.
- Immediates:
  - "beq x0,x0,-4" (32'hFE000EE3) → imm=32'hFFFFFFFC.
  - "jal x1,2048" → imm=32'h00000800, rd_we=1.
